// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_ctrl
// Brief    : Frame sequencer for the streaming Sobel datapath. Walks one
//            WIDTH x HEIGHT frame through input RAM, operator and output RAM,
//            producing read/write addresses, data enable, border mask and a
//            done handshake.
// Option   : SOBEL_FRAME_CTRL_GOLDEN_CHECK_EN enables the golden-RAM checker
//            (golden_addr_o and errors_o); otherwise both are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_frame_ctrl #(
    parameter int WIDTH    = 512,
    parameter int HEIGHT   = 512,
    parameter int ADDR_W   = 18,
    parameter int FILL_LAT = 520
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              hold_i,
    output logic [ADDR_W-1:0] in_addr_o,
    output logic              in_en_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_wr_o,
    output logic              out_mask_o,
    input  logic [7:0]        pix_data_i,
    output logic [ADDR_W-1:0] golden_addr_o,
    input  logic [7:0]        golden_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       errors_o,
    output logic [31:0]       cycle_count_o
);

    localparam int N = WIDTH * HEIGHT;

    // k runs one bit wider than the addresses so FILL_LAT+N fits
    localparam logic [ADDR_W:0]   K_ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   K_FL      = (ADDR_W+1)'(FILL_LAT);
    localparam logic [ADDR_W:0]   K_N       = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   K_END     = (ADDR_W+1)'(FILL_LAT + N);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] X_MAX     = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] X_HI      = ADDR_W'(WIDTH - 2);
    localparam logic [ADDR_W-1:0] Y_HI      = ADDR_W'(HEIGHT - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   k_q, k_d;           // k of the next active cycle to launch
    logic [ADDR_W-1:0] x_q, x_d, y_q, y_d; // location of the next pixel written
    logic [ADDR_W-1:0] in_addr_q, in_addr_d, out_addr_q, out_addr_d;
    logic              in_en_q, in_en_d, out_wr_q, out_wr_d, out_mask_q, out_mask_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              accept;

    // Next-state logic: every output is computed here for the cycle being launched
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        x_d        = x_q;
        y_d        = y_q;
        in_addr_d  = in_addr_q;
        in_en_d    = 1'b0;
        out_addr_d = out_addr_q;
        out_wr_d   = 1'b0;
        out_mask_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cycle_d    = cycle_q;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // first busy cycle is k=0: read address 0, no enable yet
                    accept     = 1'b1;
                    state_d    = S_FILL;
                    k_d        = K_ONE;
                    x_d        = '0;
                    y_d        = '0;
                    in_addr_d  = '0;
                    out_addr_d = '0;
                    busy_d     = 1'b1;
                    cycle_d    = '0;
                end
            end
            S_FILL, S_STREAM, S_DRAIN: begin
                cycle_d = cycle_q + 32'd1;
                if (!hold_i) begin
                    if (k_q == K_END) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d       = k_q + K_ONE;
                        in_addr_d = (k_q >= K_N) ? A_LAST : k_q[ADDR_W-1:0];
                        in_en_d   = 1'b1;
                        if (k_q < K_FL)
                            state_d = S_FILL;
                        else if (k_q < K_N)
                            state_d = S_STREAM;
                        else
                            state_d = S_DRAIN;
                        if (k_q >= K_FL) begin
                            out_wr_d   = 1'b1;
                            out_addr_d = (k_q == K_FL) ? '0 : out_addr_q + A_ONE;
                            out_mask_d = (x_q != '0) && (x_q <= X_HI) &&
                                         (y_q != '0) && (y_q <= Y_HI);
                            if (x_q == X_MAX) begin
                                x_d = '0;
                                y_d = y_q + A_ONE;
                            end else begin
                                x_d = x_q + A_ONE;
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            in_addr_q  <= '0;
            in_en_q    <= 1'b0;
            out_addr_q <= '0;
            out_wr_q   <= 1'b0;
            out_mask_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            x_q        <= x_d;
            y_q        <= y_d;
            in_addr_q  <= in_addr_d;
            in_en_q    <= in_en_d;
            out_addr_q <= out_addr_d;
            out_wr_q   <= out_wr_d;
            out_mask_q <= out_mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cycle_q    <= cycle_d;
        end
    end

    assign in_addr_o     = in_addr_q;
    assign in_en_o       = in_en_q;
    assign out_addr_o    = out_addr_q;
    assign out_wr_o      = out_wr_q;
    assign out_mask_o    = out_mask_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cycle_count_o = cycle_q;

`ifdef SOBEL_FRAME_CTRL_GOLDEN_CHECK_EN
    // Golden RAM has 2-cycle latency, so the written pixel is delayed to match
    logic              s1_v_q, s2_v_q;
    logic [7:0]        s1_pix_q, s2_pix_q;
    logic [31:0]       errors_q;
    logic [ADDR_W-1:0] golden_addr_q;

    // Checker pipeline runs every clock so in-flight compares finish after done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q        <= 1'b0;
            s2_v_q        <= 1'b0;
            s1_pix_q      <= '0;
            s2_pix_q      <= '0;
            errors_q      <= '0;
            golden_addr_q <= '0;
        end else begin
            s1_v_q        <= out_wr_q;
            s1_pix_q      <= pix_data_i;
            s2_v_q        <= s1_v_q;
            s2_pix_q      <= s1_pix_q;
            golden_addr_q <= out_addr_d;
            if (accept)
                errors_q <= '0;
            else if (s2_v_q && (s2_pix_q != golden_data_i))
                errors_q <= errors_q + 32'd1;
        end
    end

    assign golden_addr_o = golden_addr_q;
    assign errors_o      = errors_q;
`else
    logic w_unused_check;
    assign w_unused_check = ^{pix_data_i, golden_data_i, accept};
    assign golden_addr_o  = '0;
    assign errors_o       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_frame_ctrl
// Brief    : Directed self-checking bench for sobel_frame_ctrl on an 8x6 frame
//            with FILL_LAT=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_frame_ctrl;

    localparam int W      = 8;
    localparam int H      = 6;
    localparam int AW     = 8;
    localparam int FL     = 16;
    localparam int NPIX   = W * H;
`ifdef SOBEL_FRAME_CTRL_GOLDEN_CHECK_EN
    localparam int EXP_ERR = 2;
`else
    localparam int EXP_ERR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          hold_i = 1'b0;
    logic [AW-1:0] in_addr_o, out_addr_o, golden_addr_o;
    logic          in_en_o, out_wr_o, out_mask_o, busy_o, done_o;
    logic [7:0]    pix_data_i, golden_data_i;
    logic [31:0]   errors_o, cycle_count_o;

    sobel_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FILL_LAT(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .hold_i(hold_i),
        .in_addr_o(in_addr_o), .in_en_o(in_en_o),
        .out_addr_o(out_addr_o), .out_wr_o(out_wr_o), .out_mask_o(out_mask_o),
        .pix_data_i(pix_data_i), .golden_addr_o(golden_addr_o),
        .golden_data_i(golden_data_i), .busy_o(busy_o), .done_o(done_o),
        .errors_o(errors_o), .cycle_count_o(cycle_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_f(input int a);
        return 8'((a * 7) + 3);
    endfunction

    // Golden RAM: deliberately wrong at addresses 10 and 33
    function automatic logic [7:0] gold_f(input int a);
        return pix_f(a) ^ (((a == 10) || (a == 33)) ? 8'hFF : 8'h00);
    endfunction

    // Pixel mux: value being written at the current output address
    always_comb pix_data_i = pix_f(int'(out_addr_o));

    // Golden RAM read model with 2-cycle latency
    logic [7:0] g1 = 8'h00, g2 = 8'h00;
    always @(posedge clk) begin
        g1 <= gold_f(int'(golden_addr_o));
        g2 <= g1;
    end
    assign golden_data_i = g2;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Per-frame measurements
    int bsy, nwr, first_wr, done_cyc, done_cnt, cc_at_done, err_c0, err_end;
    int mask_ones, border_ones, bad_in, bad_wr, bad_addr, bad_mask, gold_bad, done_busy;

    // Launch a frame and check every busy cycle against an independent k model
    task automatic run_frame(input int hold_at, input int hold_len);
        int  k_m, prev_in, wa, xe, ye, exp_in;
        logic act, exp_wr, exp_mask;
        bsy = 0; nwr = 0; first_wr = -1; done_cyc = -1; done_cnt = 0; cc_at_done = -1;
        err_c0 = -1; mask_ones = 0; border_ones = 0; bad_in = 0; bad_wr = 0;
        bad_addr = 0; bad_mask = 0; gold_bad = 0; done_busy = 0;
        k_m = 0; prev_in = 0; act = 1'b1;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int j = 0; j < 200; j++) begin
            if (j == 0) err_c0 = int'(errors_o);
            if (busy_o) bsy++;
            if (out_wr_o) nwr++;
`ifdef SOBEL_FRAME_CTRL_GOLDEN_CHECK_EN
            if (golden_addr_o !== out_addr_o) gold_bad++;
`else
            if (golden_addr_o !== '0) gold_bad++;
`endif
            if (done_o) begin
                done_cnt++;
                if (busy_o) done_busy++;
                if (done_cyc < 0) begin
                    done_cyc   = j;
                    cc_at_done = int'(cycle_count_o);
                end
            end
            if (busy_o) begin
                if (act) begin
                    exp_in = (k_m < NPIX - 1) ? k_m : NPIX - 1;
                    exp_wr = (k_m >= FL) && (k_m <= FL + NPIX - 1);
                    if ((int'(in_addr_o) != exp_in) || (in_en_o !== (k_m >= 1))) bad_in++;
                    if (out_wr_o !== exp_wr) bad_wr++;
                    if (exp_wr) begin
                        wa = k_m - FL;
                        xe = wa % W;
                        ye = wa / W;
                        exp_mask = (xe >= 1) && (xe <= W - 2) && (ye >= 1) && (ye <= H - 2);
                        if (int'(out_addr_o) != wa) bad_addr++;
                        if (out_mask_o !== exp_mask) bad_mask++;
                        if (out_mask_o === 1'b1) mask_ones++;
                        if ((wa < W || wa >= NPIX - W) && out_mask_o === 1'b1) border_ones++;
                        if (first_wr < 0) first_wr = j;
                    end
                    k_m++;
                end else begin
                    if (in_en_o !== 1'b0 || out_wr_o !== 1'b0 || int'(in_addr_o) != prev_in)
                        bad_in++;
                end
                prev_in = int'(in_addr_o);
            end
            hold_i = (j >= hold_at) && (j < hold_at + hold_len);
            act    = !hold_i;
            if (done_cyc >= 0 && j >= done_cyc + 4) begin
                err_end = int'(errors_o);
                break;
            end
            @(negedge clk);
        end
        hold_i = 1'b0;
    endtask

    initial begin
        err_end = -1;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_addr", 32'(in_addr_o), 0);
        chk("rst_out_addr", 32'(out_addr_o), 0);
        chk("rst_golden_addr", 32'(golden_addr_o), 0);
        chk("rst_flags", {27'd0, in_en_o, out_wr_o, out_mask_o, busy_o, done_o}, 0);
        chk("rst_errors", errors_o, 0);
        chk("rst_cycles", cycle_count_o, 0);
        rst_n = 1'b1;

        // Frame 1: plain run with border mask and golden mismatches
        run_frame(1000, 0);
        chk("f1_busy_cycles", bsy, 64);
        chk("f1_writes", nwr, 48);
        chk("f1_in_seq", bad_in, 0);
        chk("f1_wr_seq", bad_wr, 0);
        chk("f1_out_addr_seq", bad_addr, 0);
        chk("f1_first_wr", first_wr, FL);
        chk("f1_done_cycle", done_cyc, 64);
        chk("f1_done_count", done_cnt, 1);
        chk("f1_done_busy", done_busy, 0);
        chk("f1_cycle_count", cc_at_done, 64);
        chk("f1_mask_ones", mask_ones, 24);
        chk("f1_mask_model", bad_mask, 0);
        chk("f1_border_mask", border_ones, 0);
        chk("f1_golden_addr", gold_bad, 0);
        chk("f1_errors", err_end, EXP_ERR);

        // Frame 2: 5-cycle hold mid-STREAM
        run_frame(25, 5);
        chk("f2_err_cleared", err_c0, 0);
        chk("f2_busy_cycles", bsy, 69);
        chk("f2_writes", nwr, 48);
        chk("f2_in_seq", bad_in, 0);
        chk("f2_wr_seq", bad_wr, 0);
        chk("f2_out_addr_seq", bad_addr, 0);
        chk("f2_done_cycle", done_cyc, 69);
        chk("f2_cycle_count", cc_at_done, 69);
        chk("f2_mask_model", bad_mask, 0);
        chk("f2_errors", err_end, EXP_ERR);

        // Frame 3: start ignored while busy, then asynchronous reset at k=30
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("f3_busy_rise", 32'(busy_o), 1);
        repeat (20) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("f3_restart_ignored_busy", 32'(busy_o), 1);
        chk("f3_restart_ignored_addr", 32'(in_addr_o), 21);
        repeat (9) @(negedge clk);
        chk("f3_k30_in_addr", 32'(in_addr_o), 30);
        chk("f3_k30_out_addr", 32'(out_addr_o), 14);
        #2 rst_n = 1'b0;
        #1;
        chk("f3_async_addr", {8'd0, in_addr_o, out_addr_o, golden_addr_o}, 0);
        chk("f3_async_flags", {27'd0, in_en_o, out_wr_o, out_mask_o, busy_o, done_o}, 0);
        chk("f3_async_counts", errors_o | cycle_count_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Frame 4: full frame after the abandoned one
        run_frame(1000, 0);
        chk("f4_busy_cycles", bsy, 64);
        chk("f4_writes", nwr, 48);
        chk("f4_out_addr_seq", bad_addr, 0);
        chk("f4_done_cycle", done_cyc, 64);
        chk("f4_cycle_count", cc_at_done, 64);
        chk("f4_errors", err_end, EXP_ERR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the streaming Sobel datapath: on `start` it walks one WIDTH×HEIGHT frame through the input image RAM, the `sobel_operator` line-buffer pipeline and the output image RAM. It generates all read/write addresses, the operator data enable, the border mask and a done handshake. It sits between the top-level host/testbench control and the three image RAMs plus the operator instance, replacing free-running address counters.

## Interface
- WIDTH, 512, pixels per line; must match the operator's WIDTH.
- HEIGHT, 512, lines per frame.
- ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- FILL_LAT, 520, active cycles from the first input read to the first valid operator output; must satisfy FILL_LAT < WIDTH*HEIGHT.
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  in  1  single-cycle frame request; sampled only in IDLE.
- hold  in  1  stall; 1 freezes all counters and suppresses in_en and out_wr.
- in_addr  out  ADDR_W  input RAM read address (RAM latency 1).
- in_en  out  1  operator data_en; data for address read on the previous active cycle.
- out_addr  out  ADDR_W  output RAM write address.
- out_wr  out  1  output RAM write enable.
- out_mask  out  1  1 = interior pixel (write operator result); 0 = border (write 8'h00).
- pix_data  in  8  muxed pixel being written this cycle; used only by the checker.
- golden_addr  out  ADDR_W  golden RAM read address (RAM latency 2).
- golden_data  in  8  golden RAM read data.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when the frame completes.
- errors  out  32  mismatch count for the last/current frame.
- cycle_count  out  32  clock cycles spent busy, including hold cycles.

## Operation
- States: IDLE → FILL → STREAM → DRAIN → DONE → IDLE. Let k count active (hold=0) busy cycles from 0, and N = WIDTH*HEIGHT.
- IDLE: start=1 → FILL. k, cycle_count and errors are cleared; x/y output location is cleared. start while busy is ignored.
- in_addr = min(k, N-1). Reads continue at N-1 during DRAIN to flush the operator; the flushed data is don't-care.
- in_en = 1 on active cycles with k ≥ 1.
- FILL: k < FILL_LAT. No writes occur. Transition to STREAM when k = FILL_LAT.
- STREAM/DRAIN: out_wr = 1 on active cycles with FILL_LAT ≤ k ≤ FILL_LAT+N-1, and out_addr = k-FILL_LAT.
- Output x/y track out_addr: x wraps at WIDTH-1, at which point y increments.
- out_mask = (1 ≤ x ≤ WIDTH-2) && (1 ≤ y ≤ HEIGHT-2).
- STREAM → DRAIN when k reaches N, i.e. input exhausted.
- DRAIN → DONE after the last write at k = FILL_LAT+N-1.
- DONE: done=1 for one cycle with busy=0, then IDLE.
- hold=1 in FILL/STREAM/DRAIN: k, in_addr, out_addr and x/y are frozen; in_en=0 and out_wr=0; cycle_count still increments. hold is ignored in IDLE and DONE.
- Reset (any state, any time): all outputs go to 0, state goes to IDLE. A partially written frame is abandoned.

## Timing
- Reset values: in_addr, out_addr and golden_addr are 0; in_en, out_wr, out_mask, busy and done are 0; errors and cycle_count are 0.
- Start accepted at edge E0. busy rises and in_addr=0 is presented in the cycle after E0.
- With no hold, the first out_wr occurs FILL_LAT cycles after busy rises, and done pulses FILL_LAT+N cycles after busy rises.
- All outputs are registered. There is no combinational path from start, hold or golden_data to any output.
- Counters are ADDR_W bits wide. k uses ADDR_W+1 bits so that FILL_LAT+N cannot overflow. errors and cycle_count wrap modulo 2^32.

## Configuration
- Macro: SOBEL_FRAME_CTRL_GOLDEN_CHECK_EN.
- Defined:
  - golden_addr follows out_addr.
  - A 2-stage pipeline, advancing every clock regardless of hold, carries out_wr and pix_data.
  - On stage 2 valid with pix_data ≠ golden_data, errors increments by 1.
  - Comparisons still in flight when done pulses are counted before the next start clears errors.
- Undefined: golden_addr = 0 and errors = 0 permanently; the golden_data and pix_data inputs are unused.

## Test plan
- WIDTH=8, HEIGHT=6, FILL_LAT=16, hold=0, single start pulse → busy for 64 cycles; 48 out_wr pulses with out_addr 0..47; done pulses once; cycle_count=64.
- Same frame, checking the border mask → out_mask=1 exactly for x∈1..6, y∈1..4, which is 24 writes; addresses 0–7 and 40–47 have out_mask=0.
- hold=1 for 5 cycles mid-STREAM → out_addr sequence is unbroken with no skipped or repeated addresses; done delayed by 5 cycles; cycle_count=69.
- start pulsed during STREAM, then reset=0 at k=30 → the second start has no effect; all outputs go to 0 asynchronously; a later start runs a full 64-cycle frame.
- SOBEL_FRAME_CTRL_GOLDEN_CHECK_EN defined, golden_data differs from pix_data at out_addr 10 and 33 → errors=2 after done; next start clears it to 0.
- Macro undefined, same stimulus → errors stays 0 and golden_addr stays 0.
